alu_issue_ctrl: RTL
===================

// Module: alu_issue_ctrl
// PURPOSE
//  Sequential front end that drives the 32-bit ALU. Accepts R-type ops (funct + operands)
//  on a valid/ready request port, decodes funct to ALU_control/comp, and registers operands
//  onto the ALU inputs. Captures result/zero/cout/overflow one cycle later and holds them
//  on a valid/ready response port. Sits between the decode stage and the ALU datapath.
// PARAMETERS
//  TAG_W   4   width of request tag echoed on the response
//  CNT_W   16  width of the issued-op counter (wraps)
// PORTS
//  clk_i         in   1      clock; all state on rising edge
//  rst_i         in   1      asynchronous, active-high reset
//  req_valid_i   in   1      request present
//  req_ready_o   out  1      request accepted when valid&ready
//  req_funct_i   in   6      MIPS R-type funct
//  req_src1_i    in   32     operand A
//  req_src2_i    in   32     operand B
//  req_tag_i     in   TAG_W  request tag
//  alu_rst_n_o   out  1      ALU reset (= ~rst_i)
//  alu_src1_o    out  32     registered operand A to ALU
//  alu_src2_o    out  32     registered operand B to ALU
//  alu_ctrl_o    out  4      ALU_control
//  alu_comp_o    out  3      compare select
//  alu_result_i  in   32     ALU result (combinational from alu_* outputs)
//  alu_zero_i    in   1      ALU zero
//  alu_cout_i    in   1      ALU carry out
//  alu_ovf_i     in   1      ALU overflow
//  rsp_valid_o   out  1      response present
//  rsp_ready_i   in   1      response consumed when valid&ready
//  rsp_result_o  out  32     captured result
//  rsp_flags_o   out  4      {trap, overflow, cout, zero}
//  rsp_illegal_o out  1      funct not supported
//  rsp_tag_o     out  TAG_W  echoed tag
//  issued_cnt_o  out  CNT_W  count of legal ops issued to the ALU
// BEHAVIOUR
//  - Reset: state=IDLE; every output register 0 (alu_ctrl_o=0, alu_comp_o=0, rsp_*=0, cnt=0).
//    Reset mid-operation discards the in-flight op and any pending response.
//  - Decode: 0x24 AND->0000, 0x25 OR->0001, 0x20 ADD->0010, 0x22 SUB->0110, 0x27 NOR->1100,
//    0x26 NAND->1101, 0x2A SLT->0111/comp 000, 0x2B SLTU->0111/comp 101. Any other funct is
//    illegal. alu_comp_o=000 for non-compare ops.
//  - FSM IDLE/ISSUE/RESP. req_ready_o = (IDLE) | (RESP & rsp_ready_i) (combinational).
//    IDLE/RESP + accept of legal op -> ISSUE: alu_* regs loaded, tag latched, cnt+1.
//    ISSUE -> RESP: capture alu_result_i/flags into rsp_*, rsp_valid_o=1.
//    Accept of illegal op -> RESP directly: rsp_result_o=0, flags=0, rsp_illegal_o=1;
//    alu_* regs keep their previous values; cnt unchanged.
//    RESP & rsp_ready_i & no accept -> IDLE, rsp_valid_o=0.
//    RESP & ~rsp_ready_i: all rsp_* held stable; req_ready_o=0.
//  - Latency: legal op accepted in cycle N -> rsp_valid_o high from cycle N+2; illegal -> N+1.
//    Back-to-back legal ops: one per 2 cycles.
//  - cout/overflow are taken only from the ALU and are 0 for logic/compare ops.
//  - issued_cnt_o wraps 2^CNT_W-1 -> 0 with no flag.
// CONFIGURATION
//  ALU_OVF_TRAP_EN defined: ADD/SUB with alu_ovf_i=1 in ISSUE -> rsp_result_o=0,
//    rsp_flags_o[3]=1 (trap), overflow flag still reported.
//  Undefined: rsp_flags_o[3] tied 0; result always passed through unchanged.
// TESTING
//  1 Reset asserted mid-ISSUE -> next cycle rsp_valid_o=0, req_ready_o=1, issued_cnt_o=0.
//  2 ADD 0x7FFFFFFF+1, tag 3 -> N+2 result 0x80000000, flags ovf=1, cout=0, tag 3;
//    with ALU_OVF_TRAP_EN result 0, trap=1.
//  3 SUB 5-5 -> result 0, zero=1, cout=1; SLT -1,1 -> result 1; SLTU -1,1 -> result 0.
//  4 funct 0x3F -> N+1 rsp_illegal_o=1, result 0, issued_cnt_o unchanged.
//  5 rsp_ready_i low 5 cycles with req_valid_i high -> req_ready_o=0, rsp_* stable;
//    ready high -> new op accepted same cycle, its response at +2.
//  6 CNT_W=2, issue 5 legal ops -> issued_cnt_o=1 after wrap.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// Purpose: issue front end for the 32-bit ALU; decodes R-type funct, registers operands, captures result.
// Latency: legal op accepted in cycle N -> response valid from N+2; illegal op -> N+1; one legal op per 2 cycles.
// Backpressure: a held response (rsp_valid_o & ~rsp_ready_i) freezes rsp_* and drops req_ready_o.
//
// Ports:
//   clk_i, rst_i                      clock, asynchronous active-high reset
//   req_valid_i/req_ready_o           request handshake; req_funct_i, req_src1_i, req_src2_i, req_tag_i payload
//   alu_rst_n_o                       ALU reset (~rst_i)
//   alu_src1_o/alu_src2_o             registered operands to the ALU
//   alu_ctrl_o/alu_comp_o             decoded ALU_control / compare select
//   alu_result_i/zero/cout/ovf        combinational ALU outputs
//   rsp_valid_o/rsp_ready_i           response handshake; rsp_result_o, rsp_flags_o {trap,ovf,cout,zero},
//                                     rsp_illegal_o, rsp_tag_o payload
//   issued_cnt_o                      wrapping count of legal ops issued to the ALU
// Build option: define ALU_OVF_TRAP_EN to zero the result and raise the trap flag on ADD/SUB overflow.

module alu_issue_ctrl #(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [5:0]       req_funct_i,
  input  logic [31:0]      req_src1_i,
  input  logic [31:0]      req_src2_i,
  input  logic [TAG_W-1:0] req_tag_i,
  output logic             alu_rst_n_o,
  output logic [31:0]      alu_src1_o,
  output logic [31:0]      alu_src2_o,
  output logic [3:0]       alu_ctrl_o,
  output logic [2:0]       alu_comp_o,
  input  logic [31:0]      alu_result_i,
  input  logic             alu_zero_i,
  input  logic             alu_cout_i,
  input  logic             alu_ovf_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [31:0]      rsp_result_o,
  output logic [3:0]       rsp_flags_o,
  output logic             rsp_illegal_o,
  output logic [TAG_W-1:0] rsp_tag_o,
  output logic [CNT_W-1:0] issued_cnt_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic             dec_legal;
  logic [3:0]       dec_ctrl;
  logic [2:0]       dec_comp;
  logic             accept;
  logic             load_op;
  logic             load_ill;
  logic             capture;
  logic             drop_rsp;
  logic             trap;
  logic [31:0]      result_cap;
  logic [TAG_W-1:0] tag_q;

  assign alu_rst_n_o = ~rst_i;

  // funct -> ALU_control / compare select
  always_comb begin
    dec_legal = 1'b1;
    dec_ctrl  = 4'b0000;
    dec_comp  = 3'b000;
    case (req_funct_i)
      6'h24:   dec_ctrl = 4'b0000;
      6'h25:   dec_ctrl = 4'b0001;
      6'h20:   dec_ctrl = 4'b0010;
      6'h22:   dec_ctrl = 4'b0110;
      6'h27:   dec_ctrl = 4'b1100;
      6'h26:   dec_ctrl = 4'b1101;
      6'h2A:   dec_ctrl = 4'b0111;
      6'h2B: begin
        dec_ctrl = 4'b0111;
        dec_comp = 3'b101;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, RESP: begin
        if (accept)                           state_d = dec_legal ? ISSUE : RESP;
        else if (state_q == RESP && rsp_ready_i) state_d = IDLE;
      end
      ISSUE:   state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  // handshake and datapath enables
  always_comb begin
    req_ready_o = (state_q == IDLE) | ((state_q == RESP) & rsp_ready_i);
    accept      = req_valid_i & req_ready_o;
    load_op     = accept & dec_legal;
    load_ill    = accept & ~dec_legal;
    capture     = (state_q == ISSUE);
    drop_rsp    = (state_q == RESP) & rsp_ready_i & ~accept;
  end

`ifdef ALU_OVF_TRAP_EN
  // only ADD/SUB can trap; ALU_control identifies them since SLT/SLTU use 0111
  assign trap = ((alu_ctrl_o == 4'b0010) | (alu_ctrl_o == 4'b0110)) & alu_ovf_i;
`else
  assign trap = 1'b0;
`endif

  assign result_cap = trap ? 32'd0 : alu_result_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      alu_src1_o    <= '0;
      alu_src2_o    <= '0;
      alu_ctrl_o    <= '0;
      alu_comp_o    <= '0;
      tag_q         <= '0;
      issued_cnt_o  <= '0;
      rsp_valid_o   <= 1'b0;
      rsp_result_o  <= '0;
      rsp_flags_o   <= '0;
      rsp_illegal_o <= 1'b0;
      rsp_tag_o     <= '0;
    end else begin
      if (load_op) begin
        alu_src1_o   <= req_src1_i;
        alu_src2_o   <= req_src2_i;
        alu_ctrl_o   <= dec_ctrl;
        alu_comp_o   <= dec_comp;
        tag_q        <= req_tag_i;
        issued_cnt_o <= issued_cnt_o + CNT_W'(1);
        rsp_valid_o  <= 1'b0;
      end
      // illegal ops never touch the ALU; answer straight from the request
      if (load_ill) begin
        rsp_valid_o   <= 1'b1;
        rsp_result_o  <= '0;
        rsp_flags_o   <= '0;
        rsp_illegal_o <= 1'b1;
        rsp_tag_o     <= req_tag_i;
      end
      if (capture) begin
        rsp_valid_o   <= 1'b1;
        rsp_result_o  <= result_cap;
        rsp_flags_o   <= {trap, alu_ovf_i, alu_cout_i, alu_zero_i};
        rsp_illegal_o <= 1'b0;
        rsp_tag_o     <= tag_q;
      end
      if (drop_rsp) rsp_valid_o <= 1'b0;
    end
  end

endmodule
